// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks an active-low row drive, debounces the first
// column seen low, and reports the confirmed key with a one-cycle dataReady strobe.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  cols,
    output logic [3:0]  rows,
    output logic [31:0] foundRow,
    output logic [31:0] foundCol,
    output logic        dataReady
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        DEBOUNCE = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [1:0]      row_idx, row_idx_n;
    logic [1:0]      col_idx, col_idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      found_row, found_row_n;
    logic [1:0]      found_col, found_col_n;
    logic            ready_n;
    logic [3:0]      rows_n;
    logic [2:0]      col_meta, col_s;

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_meta <= 3'b111;
            col_s    <= 3'b111;
        end else begin
            col_meta <= cols;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            cnt       <= '0;
            found_row <= 2'd0;
            found_col <= 2'd0;
            dataReady <= 1'b0;
            rows      <= 4'b1111;
        end else begin
            state     <= state_n;
            row_idx   <= row_idx_n;
            col_idx   <= col_idx_n;
            cnt       <= cnt_n;
            found_row <= found_row_n;
            found_col <= found_col_n;
            dataReady <= ready_n;
            rows      <= rows_n;
        end
    end

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        col_idx_n   = col_idx;
        cnt_n       = cnt;
        found_row_n = found_row;
        found_col_n = found_col;
        ready_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SCAN;
                    row_idx_n = 2'd0;
                    cnt_n     = '0;
                end
            end

            SCAN: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (cnt == DWELL_LAST) begin
                    cnt_n = '0;
                    if (col_s != 3'b111) begin
                        // Lowest column index wins when several are low
                        state_n   = DEBOUNCE;
                        col_idx_n = !col_s[0] ? 2'd0 : (!col_s[1] ? 2'd1 : 2'd2);
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            DEBOUNCE: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (col_s[col_idx]) begin
                    state_n   = SCAN;
                    row_idx_n = row_idx + 2'd1;
                    cnt_n     = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n     = HOLD;
                    cnt_n       = '0;
                    found_row_n = row_idx;
                    found_col_n = col_idx;
                    ready_n     = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            HOLD: begin
                if (!col_s[col_idx]) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n     = '0;
                    row_idx_n = 2'd0;
                    state_n   = start ? SCAN : IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: state_n = IDLE;
        endcase

        rows_n = (state_n == IDLE) ? 4'b1111 : ~(4'b0001 << row_idx_n);
    end

    assign foundRow = 32'(found_row);
    assign foundCol = 32'(found_col);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model that pulls the
// pressed key's columns low whenever its row is driven.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [2:0]  cols;
    logic [3:0]  rows;
    logic [31:0] foundRow;
    logic [31:0] foundCol;
    logic        dataReady;

    int checks;
    int failures;

    // Keypad model: a pressed key on phys_row pulls phys_mask columns low while its row is driven
    logic       phys_en;
    logic [1:0] phys_row;
    logic [2:0] phys_mask;
    logic       force_en;
    logic [2:0] force_cols;

    assign cols = force_en ? force_cols :
                  (phys_en && !rows[phys_row]) ? ~phys_mask : 3'b111;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .cols      (cols),
        .rows      (rows),
        .foundRow  (foundRow),
        .foundCol  (foundCol),
        .dataReady (dataReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        logic bad;
        resetn = 1'b0; start = 1'b0; phys_en = 1'b0; force_en = 1'b0;
        phys_row = 2'd0; phys_mask = 3'b000; force_cols = 3'b111;
        repeat (2) @(negedge clock);
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL reset_rows got=%b exp=1111", rows); end
        checks++; if (foundRow !== 32'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", foundRow); end
        checks++; if (foundCol !== 32'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", foundCol); end
        checks++; if (dataReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", dataReady); end
        resetn = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rows !== 4'b1111 || dataReady !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL idle_after_reset rows=%b ready=%b exp rows=1111 ready=0", rows, dataReady); end
    endtask

    task automatic test_scan_cycle();
        logic [3:0] one;
        logic [3:0] exp;
        int pulses;
        one = 4'b0001;
        pulses = 0;
        start = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            exp = ~(one << (((k - 1) / 4) % 4));
            if (dataReady === 1'b1) pulses++;
            checks++; if (rows !== exp) begin failures++; $display("FAIL scan_rows k=%0d got=%b exp=%b", k, rows, exp); end
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL scan_no_ready pulses=%0d exp=0", pulses); end
        start = 1'b0;
        @(negedge clock);
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL scan_stop_rows got=%b exp=1111", rows); end
    endtask

    task automatic test_press_hold();
        int lat;
        int pulses;
        logic bad;
        phys_row = 2'd2; phys_mask = 3'b100; phys_en = 1'b1;
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clock);
            if (dataReady === 1'b1) lat = k;
        end
        checks++; if (lat != 21) begin failures++; $display("FAIL press_latency got=%0d exp=21", lat); end
        checks++; if (foundRow !== 32'd2) begin failures++; $display("FAIL press_row got=%0d exp=2", foundRow); end
        checks++; if (foundCol !== 32'd2) begin failures++; $display("FAIL press_col got=%0d exp=2", foundCol); end
        checks++; if (rows !== 4'b1011) begin failures++; $display("FAIL press_rows got=%b exp=1011", rows); end
        pulses = 0; bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dataReady === 1'b1) pulses++;
            if (rows !== 4'b1011) bad = 1'b1;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL hold_single_pulse extra=%0d exp=0", pulses); end
        checks++; if (bad) begin failures++; $display("FAIL hold_rows got=%b exp=1011", rows); end
        phys_en = 1'b0;
        repeat (9) @(negedge clock);
        checks++; if (rows !== 4'b1011) begin failures++; $display("FAIL release_hold_rows got=%b exp=1011", rows); end
        @(negedge clock);
        checks++; if (rows !== 4'b1110) begin failures++; $display("FAIL release_resume_rows got=%b exp=1110", rows); end
        start = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_bounce();
        int pulses;
        start = 1'b1;
        @(negedge clock);
        force_en = 1'b1; force_cols = 3'b101;
        repeat (3) @(negedge clock);
        force_cols = 3'b111;
        @(negedge clock);
        checks++; if (rows !== 4'b1110) begin failures++; $display("FAIL bounce_debounce_rows got=%b exp=1110", rows); end
        repeat (2) @(negedge clock);
        checks++; if (rows !== 4'b1101) begin failures++; $display("FAIL bounce_resume_rows got=%b exp=1101", rows); end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dataReady === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL bounce_no_ready pulses=%0d exp=0", pulses); end
        checks++; if (foundRow !== 32'd2 || foundCol !== 32'd2) begin failures++; $display("FAIL bounce_found_kept got=%0d/%0d exp=2/2", foundRow, foundCol); end
        start = 1'b0; force_en = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_priority();
        int lat;
        phys_row = 2'd1; phys_mask = 3'b111; phys_en = 1'b1;
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clock);
            if (dataReady === 1'b1) lat = k;
        end
        checks++; if (lat != 17) begin failures++; $display("FAIL prio_latency got=%0d exp=17", lat); end
        checks++; if (foundRow !== 32'd1) begin failures++; $display("FAIL prio_row got=%0d exp=1", foundRow); end
        checks++; if (foundCol !== 32'd0) begin failures++; $display("FAIL prio_col got=%0d exp=0", foundCol); end
        phys_en = 1'b0;
        repeat (14) @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL prio_idle_rows got=%b exp=1111", rows); end
    endtask

    task automatic test_abort();
        int pulses;
        int lat;
        phys_row = 2'd3; phys_mask = 3'b010; phys_en = 1'b1;
        start = 1'b1;
        repeat (20) @(negedge clock);
        checks++; if (rows !== 4'b0111) begin failures++; $display("FAIL abort_debounce_rows got=%b exp=0111", rows); end
        start = 1'b0;
        @(negedge clock);
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL abort_rows got=%b exp=1111", rows); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (dataReady === 1'b1) pulses++;
            @(negedge clock);
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL abort_no_ready pulses=%0d exp=0", pulses); end
        checks++; if (foundRow !== 32'd1 || foundCol !== 32'd0) begin failures++; $display("FAIL abort_found_kept got=%0d/%0d exp=1/0", foundRow, foundCol); end

        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100 && lat == 0; k++) begin
            @(negedge clock);
            if (dataReady === 1'b1) lat = k;
        end
        checks++; if (lat != 25) begin failures++; $display("FAIL row3_latency got=%0d exp=25", lat); end
        checks++; if (foundRow !== 32'd3 || foundCol !== 32'd1) begin failures++; $display("FAIL row3_found got=%0d/%0d exp=3/1", foundRow, foundCol); end
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL midhold_reset_rows got=%b exp=1111", rows); end
        checks++; if (foundRow !== 32'd0 || foundCol !== 32'd0) begin failures++; $display("FAIL midhold_reset_found got=%0d/%0d exp=0/0", foundRow, foundCol); end
        checks++; if (dataReady !== 1'b0) begin failures++; $display("FAIL midhold_reset_ready got=%b exp=0", dataReady); end
        phys_en = 1'b0; start = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (rows !== 4'b1111) begin failures++; $display("FAIL post_reset_idle got=%b exp=1111", rows); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_scan_cycle();
        test_press_hold();
        test_bounce();
        test_priority();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scanner for a 4-row x 3-column matrix keypad (ATM coin-machine processor front end).
- Drives one row low at a time and samples the column lines, which have pull-ups and read low when a key is pressed.
- Debounces each press and reports the pressed key as zero-extended 32-bit row and column indices, with a one-cycle dataReady strobe, for processor register consumption.

Parameters:
- SCAN_DIV, 16, clock cycles each row is driven before the columns are sampled (min 4).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to confirm a press and to confirm a release (min 2).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  level enable; scanning runs while high.
- cols  input  3  column lines, active-low pressed, asynchronous to clock.
- rows  output  4  row drives, active-low; exactly one bit low while scanning, 4'b1111 otherwise.
- foundRow  output  32  row index 0..3 of the last confirmed key, upper 30 bits zero.
- foundCol  output  32  column index 0..2 of the last confirmed key, upper 30 bits zero.
- dataReady  output  1  one-cycle pulse when foundRow/foundCol update.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, rows=4'b1111, foundRow=0, foundCol=0, dataReady=0.
  - row index=0, counters=0, column synchronizer=3'b111.
- Column input: cols passes through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
- Key encoding: the key is (row index r, column index c); row r is driven low with rows = ~(1<<r).
- Multiple columns low at sample time: the lowest column index wins. Other simultaneously pressed rows are ignored until release.
- IDLE:
  - rows=1111.
  - start=1 -> SCAN with r=0 and dwell counter cleared.
- SCAN:
  - Drive row r for SCAN_DIV cycles.
  - On the last dwell cycle, sample the synchronized cols.
    - Any bit low -> capture c, go to DEBOUNCE (same r).
    - All bits high -> r=(r+1) mod 4, wrapping 3->0, and restart the dwell.
- DEBOUNCE:
  - Keep driving row r; count consecutive cycles with col c low.
  - Col c goes high before the count reaches DEBOUNCE_CYCLES -> back to SCAN with r=(r+1) mod 4. No output change.
  - Count reaches DEBOUNCE_CYCLES -> foundRow=r, foundCol=c, dataReady=1 for exactly one cycle, go to HOLD.
- HOLD:
  - Keep driving row r; wait for col c high for DEBOUNCE_CYCLES consecutive cycles. Any low sample clears the count.
  - When the count completes: start=1 -> SCAN with r=0; start=0 -> IDLE.
  - A held key never produces a second dataReady.
- Abort rules:
  - start=0 while in SCAN or DEBOUNCE -> IDLE on the next edge; no dataReady; foundRow/foundCol unchanged.
  - start is ignored while in HOLD.
- Output holding: foundRow/foundCol hold their value until the next confirmed press. They are not cleared by start=0; only reset clears them.
- Reset mid-operation: immediate return to the reset values; any pending press is discarded.
- Minimum press-to-dataReady latency: 2 (sync) + dwell remainder + DEBOUNCE_CYCLES cycles.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Reset with resetn=0, cols=111, start=0 -> rows=1111, foundRow=0, foundCol=0, dataReady=0. Stays IDLE after release with start=0.
2. start=1, cols=111 for 64 cycles -> rows cycles 1110, 1101, 1011, 0111, 1110..., 4 cycles each. dataReady never asserted.
3. start=1; pull cols[2]=0 only while rows=1011 (row 2), held 40 cycles -> single dataReady pulse with foundRow=2, foundCol=2. rows stays 1011 until cols[2] has been high for 8 cycles, then scanning resumes at rows=1110.
4. Bounce: cols[1] low for 3 cycles during row 0 then high -> no dataReady; scanning resumes at row 1.
5. cols=000 while row 1 is driven -> foundRow=1, foundCol=0 (lowest column priority).
6. Abort: start deasserted mid-DEBOUNCE -> rows=1111 next cycle, no dataReady, foundRow/foundCol keep their previous values. Then assert resetn=0 mid-HOLD -> all outputs return to reset values immediately.
